debug_unit_dump_sequencer: RTL and testbench

//  Sequences the debug dump of the halted/stepped MIPS core through the 32-bit UART TX path.
//  On a start request it snapshots PC and cycle count, then sends one 32-bit word per item:
//  PC, registers 0..N_REGISTERS-1, data memory words 0..N_MEM_WORDS-1, cycle count.

---
 rtl/debug_unit_dump_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_debug_unit_dump_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit_dump_sequencer.sv
// debug_unit_dump_sequencer
// Sends a debug dump over the 32-bit UART TX path, one word per item in this order:
// PC snapshot, registers 0..N_REGISTERS-1, data memory words 0..N_MEM_WORDS-1, then the
// cycle-count snapshot. Each item takes three steps: fetch the item (drive the read
// address and wait RD_LAT cycles), send it (capture the word and pulse start), and wait
// for the UART to report the word done. All outputs are registered.
module debug_unit_dump_sequencer #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned N_REGISTERS = 32,
    parameter int unsigned N_MEM_WORDS = 32,
    parameter int unsigned NB_REG_ADDR = 5,
    parameter int unsigned NB_MEM_ADDR = 32,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_cycles,
    input  logic [NB_DATA-1:0]     i_reg_data,
    input  logic [NB_DATA-1:0]     i_mem_data,
    input  logic                   i_uart_tx_32b_done,
    output logic [NB_DATA-1:0]     o_uart_tx_data,
    output logic                   o_uart_tx_32b_start,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned TOTAL = N_REGISTERS + N_MEM_WORDS + 2;
    localparam int unsigned IDX_W = $clog2(TOTAL);
    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               state_q,    state_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [LAT_W-1:0]     lat_q,      lat_d;
    logic [NB_DATA-1:0]   pc_snap_q,  pc_snap_d;
    logic [NB_DATA-1:0]   cyc_snap_q, cyc_snap_d;
    logic [NB_DATA-1:0]   tx_data_q,  tx_data_d;
    logic                 start_q,    start_d;
    logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
    logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic [NB_DATA-1:0]   word_s;

    // Register index for an item; items outside the register range give address 0.
    function automatic logic [NB_REG_ADDR-1:0] reg_addr_of(input logic [IDX_W-1:0] idx);
        int unsigned sel;
        sel = 32'(idx);
        if ((sel >= 32'd1) && (sel <= N_REGISTERS)) begin
            reg_addr_of = NB_REG_ADDR'(sel - 32'd1);
        end else begin
            reg_addr_of = {NB_REG_ADDR{1'b0}};
        end
    endfunction

    // Memory byte address for an item; items outside the memory range give address 0.
    function automatic logic [NB_MEM_ADDR-1:0] mem_addr_of(input logic [IDX_W-1:0] idx);
        int unsigned sel;
        sel = 32'(idx);
        if ((sel >= (N_REGISTERS + 32'd1)) && (sel <= (N_REGISTERS + N_MEM_WORDS))) begin
            mem_addr_of = NB_MEM_ADDR'((sel - 32'd1 - N_REGISTERS) * 32'd4);
        end else begin
            mem_addr_of = {NB_MEM_ADDR{1'b0}};
        end
    endfunction

    // Choose which source supplies the word for the current item.
    always_comb begin
        word_s = {NB_DATA{1'b0}};
        if (idx_q == {IDX_W{1'b0}}) begin
            word_s = pc_snap_q;
        end else if (32'(idx_q) <= N_REGISTERS) begin
            word_s = i_reg_data;
        end else if (idx_q != IDX_LAST) begin
            word_s = i_mem_data;
        end else begin
            word_s = cyc_snap_q;
        end
    end

    // Compute the next state and the next value of every registered output.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        pc_snap_d  = pc_snap_q;
        cyc_snap_d = cyc_snap_q;
        tx_data_d  = tx_data_q;
        start_d    = 1'b0;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    pc_snap_d  = i_pc;
                    cyc_snap_d = i_cycles;
                    idx_d      = {IDX_W{1'b0}};
                    lat_d      = {LAT_W{1'b0}};
                    reg_addr_d = reg_addr_of({IDX_W{1'b0}});
                    mem_addr_d = mem_addr_of({IDX_W{1'b0}});
                    busy_d     = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_SEND;
                end else begin
                    lat_d   = lat_q + LAT_W'(1);
                end
            end
            ST_SEND: begin
                tx_data_d = word_s;
                start_d   = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse in the same cycle as our start pulse cannot belong to this word.
                if (i_uart_tx_32b_done && !start_q) begin
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        lat_d      = {LAT_W{1'b0}};
                        reg_addr_d = reg_addr_of(idx_q + IDX_W'(1));
                        mem_addr_d = mem_addr_of(idx_q + IDX_W'(1));
                        state_d    = ST_FETCH;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            lat_q      <= {LAT_W{1'b0}};
            pc_snap_q  <= {NB_DATA{1'b0}};
            cyc_snap_q <= {NB_DATA{1'b0}};
            tx_data_q  <= {NB_DATA{1'b0}};
            start_q    <= 1'b0;
            reg_addr_q <= {NB_REG_ADDR{1'b0}};
            mem_addr_q <= {NB_MEM_ADDR{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            pc_snap_q  <= pc_snap_d;
            cyc_snap_q <= cyc_snap_d;
            tx_data_q  <= tx_data_d;
            start_q    <= start_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_uart_tx_data      = tx_data_q;
    assign o_uart_tx_32b_start = start_q;
    assign o_reg_addr          = reg_addr_q;
    assign o_mem_addr          = mem_addr_q;
    assign o_busy              = busy_q;
    assign o_done              = done_q;

endmodule

// File: tb/tb_debug_unit_dump_sequencer.sv
// Directed bench for debug_unit_dump_sequencer: 4 registers, 2 memory words, RD_LAT=1,
// and a UART model that returns done 10 cycles after each start pulse.
module tb_debug_unit_dump_sequencer;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_pc = 32'h0000_0040;
    logic [31:0] i_cycles = 32'h0000_0099;
    logic [31:0] reg_data = 32'h0;
    logic [31:0] mem_data = 32'h0;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        uart_done;
    logic [31:0] o_uart_tx_data;
    logic        o_uart_tx_32b_start;
    logic [1:0]  o_reg_addr;
    logic [31:0] o_mem_addr;
    logic        o_busy;
    logic        o_done;

    logic [31:0] regs [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] memw [2] = '{32'hAA, 32'hBB};

    int cyc = 0;
    int rem = 0;
    int busy_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] w_q [$];
    logic [1:0]  ra_q [$];
    logic [31:0] ma_q [$];
    int          s_cyc_q [$];
    int          d_cyc_q [$];

    assign uart_done = model_done | spur_done;

    debug_unit_dump_sequencer #(
        .NB_DATA(32), .N_REGISTERS(4), .N_MEM_WORDS(2),
        .NB_REG_ADDR(2), .NB_MEM_ADDR(32), .RD_LAT(1)
    ) dut (
        .i_clock(clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_pc(i_pc),
        .i_cycles(i_cycles),
        .i_reg_data(reg_data),
        .i_mem_data(mem_data),
        .i_uart_tx_32b_done(uart_done),
        .o_uart_tx_data(o_uart_tx_data),
        .o_uart_tx_32b_start(o_uart_tx_32b_start),
        .o_reg_addr(o_reg_addr),
        .o_mem_addr(o_mem_addr),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Cycle counter and one-cycle-latency register/memory read model.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        reg_data <= regs[o_reg_addr];
        mem_data <= (o_mem_addr[31:3] == 29'd0 && o_mem_addr[1:0] == 2'd0)
                    ? memw[o_mem_addr[2]] : 32'hBAD0_BAD0;
    end

    // UART model: done is high exactly 10 cycles after the start-pulse cycle.
    always @(posedge clk) begin
        if (i_reset) begin
            rem        <= 0;
            model_done <= 1'b0;
        end else if (o_uart_tx_32b_start) begin
            rem        <= 10;
            model_done <= 1'b0;
        end else if (rem != 0) begin
            rem        <= rem - 1;
            model_done <= (rem == 2);
        end else begin
            model_done <= 1'b0;
        end
    end

    // Monitor: log start pulses, done pulses and busy cycles at the falling edge.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_uart_tx_32b_start) begin
                w_q.push_back(o_uart_tx_data);
                ra_q.push_back(o_reg_addr);
                ma_q.push_back(o_mem_addr);
                s_cyc_q.push_back(cyc);
            end
            if (o_done) d_cyc_q.push_back(cyc);
            if (o_busy) busy_cnt = busy_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        w_q.delete(); ra_q.delete(); ma_q.delete(); s_cyc_q.delete(); d_cyc_q.delete();
        busy_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int n);
        int budget;
        budget = 400;
        while (d_cyc_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check_eq({tag, "_timeout"}, d_cyc_q.size(), n);
    endtask

    task automatic wait_starts(input string tag, input int n);
        int budget;
        budget = 400;
        while (s_cyc_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check_eq({tag, "_timeout"}, s_cyc_q.size(), n);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
        check_eq({tag, "_done"},  {31'd0, o_done}, 32'd0);
        check_eq({tag, "_start"}, {31'd0, o_uart_tx_32b_start}, 32'd0);
        check_eq({tag, "_data"},  o_uart_tx_data, 32'd0);
        check_eq({tag, "_raddr"}, {30'd0, o_reg_addr}, 32'd0);
        check_eq({tag, "_maddr"}, o_mem_addr, 32'd0);
    endtask

    // Check one complete dump that began with i_start sampled at the end of cycle c0.
    task automatic check_dump(input string tag, input logic [31:0] pc_e,
                              input logic [31:0] cyc_e, input int c0);
        logic [31:0] exp_w [8];
        logic [31:0] got;
        exp_w = '{pc_e, 32'h11, 32'h22, 32'h33, 32'h44, 32'hAA, 32'hBB, cyc_e};
        check_eq({tag, "_nwords"}, w_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            got = (i < w_q.size()) ? w_q[i] : 32'hDEAD_BEEF;
            check_eq($sformatf("%s_word%0d", tag, i), got, exp_w[i]);
        end
        for (int i = 1; i < 5; i++) begin
            got = (i < ra_q.size()) ? {30'd0, ra_q[i]} : 32'hDEAD_BEEF;
            check_eq($sformatf("%s_raddr%0d", tag, i), got, 32'(i - 1));
        end
        for (int i = 5; i < 7; i++) begin
            got = (i < ma_q.size()) ? ma_q[i] : 32'hDEAD_BEEF;
            check_eq($sformatf("%s_maddr%0d", tag, i), got, 32'((i - 5) * 4));
        end
        got = (s_cyc_q.size() > 0) ? 32'(s_cyc_q[0] - c0) : 32'hDEAD_BEEF;
        check_eq({tag, "_first_start_cyc"}, got, 32'd3);
        check_eq({tag, "_ndone"}, d_cyc_q.size(), 32'd1);
        got = (d_cyc_q.size() > 0) ? 32'(d_cyc_q[0] - c0) : 32'hDEAD_BEEF;
        check_eq({tag, "_done_cyc"}, got, 32'd105);
    endtask

    initial begin
        int c0;
        int dc;
        step(3);
        i_reset = 1'b0;
        step(1);
        check_zero("reset");

        // Full dump, timing, busy window and snapshot behaviour.
        clear_logs();
        c0 = cyc;
        i_start = 1'b1;
        step(1);
        i_start  = 1'b0;
        i_pc     = 32'h0000_0080;
        i_cycles = 32'h0000_1234;
        @(negedge clk);
        check_eq("busy_cycle1", {31'd0, o_busy}, 32'd1);
        wait_done("dump1", 1);
        step(3);
        check_dump("dump1", 32'h40, 32'h99, c0);
        check_eq("dump1_busy_cycles", busy_cnt, 32'd105);
        check_eq("dump1_busy_after", {31'd0, o_busy}, 32'd0);

        // Spurious start/done during FETCH, SEND and the start-pulse cycle of item 2.
        clear_logs();
        i_pc = 32'h40; i_cycles = 32'h99;
        c0 = cyc;
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        while (cyc < c0 + 27) step(1);
        i_start = 1'b1; spur_done = 1'b1;
        step(3);
        i_start = 1'b0; spur_done = 1'b0;
        wait_done("spur", 1);
        step(3);
        check_dump("spur", 32'h40, 32'h99, c0);

        // Reset mid-dump, then a fresh dump starts again from the PC word.
        clear_logs();
        c0 = cyc;
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        wait_starts("rst", 3);
        step(2);
        i_reset = 1'b1;
        step(1);
        i_reset = 1'b0;
        check_zero("midreset");
        step(20);
        check_eq("midreset_nstarts", s_cyc_q.size(), 32'd3);
        check_eq("midreset_ndone", d_cyc_q.size(), 32'd0);
        clear_logs();
        i_pc = 32'h50;
        c0 = cyc;
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        wait_done("restart", 1);
        step(3);
        check_dump("restart", 32'h50, 32'h99, c0);

        // Start held high: second dump's first start pulse 4 cycles after first o_done.
        clear_logs();
        i_pc = 32'h40;
        c0 = cyc;
        i_start = 1'b1;
        wait_done("b2b", 1);
        dc = (d_cyc_q.size() > 0) ? d_cyc_q[0] : 0;
        check_eq("b2b_done_cyc", 32'(dc - c0), 32'd105);
        wait_starts("b2b", 9);
        i_start = 1'b0;
        if (s_cyc_q.size() > 8) begin
            check_eq("b2b_second_start", 32'(s_cyc_q[8] - dc), 32'd4);
            check_eq("b2b_second_word0", w_q[8], 32'h40);
        end else begin
            check_eq("b2b_second_nstarts", s_cyc_q.size(), 32'd9);
        end
        wait_done("b2b2", 2);
        step(3);
        check_eq("b2b_total_words", w_q.size(), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
